// File: rtl/stacked_reducer_pkg.sv
// Shared types and saturating-arithmetic helpers for the stacked systolic reducer.
package stacked_reducer_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_SUM   = 2'b01,
        MODE_ACCUM = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // Helpers work on one extra bit beyond the widest supported lane so a raw sum never wraps.
    localparam int MAX_W = 32;
    typedef logic signed [MAX_W:0] wide_t;

    function automatic wide_t SAT_MAX(input int width);
        return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t SAT_MIN(input int width);
        return -(wide_t'(1) <<< (width - 1));
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int width);
        wide_t s;
        s = a + b;
        if (s > SAT_MAX(width)) begin
            return SAT_MAX(width);
        end
        if (s < SAT_MIN(width)) begin
            return SAT_MIN(width);
        end
        return s;
    endfunction

    function automatic int tree_nodes(input int lanes, input int level);
        return (lanes + (1 << level) - 1) >> level;
    endfunction

endpackage

// File: rtl/stacked_reducer_sat_add.sv
// One registered two-input saturating adder node of the reduction tree.
// The o_sat port exists only when STACKED_REDUCER_SAT_FLAG_EN is defined.
module stacked_reducer_sat_add
    import stacked_reducer_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic                    clk,
    input  logic                    i_en,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_sum
`ifdef STACKED_REDUCER_SAT_FLAG_EN
    ,
    output logic                    o_sat
`endif
);

    always_ff @(posedge clk) begin
        if (i_en) begin
            o_sum <= WIDTH'(sat_add(wide_t'(i_a), wide_t'(i_b), WIDTH));
`ifdef STACKED_REDUCER_SAT_FLAG_EN
            o_sat <= (sat_add(wide_t'(i_a), wide_t'(i_b), WIDTH) != (wide_t'(i_a) + wide_t'(i_b)));
`endif
        end
    end

endmodule

// File: rtl/stacked_systolic_reducer.sv
// Back-pressured PASS/SUM/ACCUM reduction stage behind LANE_COUNT stacked systolic arrays.
// Defining STACKED_REDUCER_SAT_FLAG_EN adds the sat_flag output and its tracking logic.
module stacked_systolic_reducer
    import stacked_reducer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LANE_COUNT = 3,
    parameter int ACC_LEN    = 4
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ce,
    input  logic [1:0]                    mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH*LANE_COUNT-1:0]   y_ins,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH*LANE_COUNT-1:0]   y_out
`ifdef STACKED_REDUCER_SAT_FLAG_EN
    ,
    output logic                          sat_flag
`endif
);

    localparam int TREE_DEPTH = $clog2(LANE_COUNT);
    localparam int CNT_W      = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int BUS_W      = WIDTH * LANE_COUNT;

    logic                    w_adv;
    logic [TREE_DEPTH:1]     r_vld_p;
    mode_e                   r_mode_p [1:TREE_DEPTH];
    logic [BUS_W-1:0]        r_pass_p [1:TREE_DEPTH];
    logic signed [WIDTH-1:0] w_node   [0:TREE_DEPTH][0:LANE_COUNT-1];

    logic                    w_tvld;
    mode_e                   w_tmode;
    logic signed [WIDTH-1:0] w_sum;
    logic signed [WIDTH-1:0] w_acc_next;
    logic                    w_last;
    logic                    w_emit;
    logic                    w_acc_keep;
    logic [BUS_W-1:0]        w_data;

    logic signed [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]        r_acc_cnt;

`ifdef STACKED_REDUCER_SAT_FLAG_EN
    logic [LANE_COUNT-1:0]   w_nsat    [1:TREE_DEPTH];
    logic                    w_lvl_sat [1:TREE_DEPTH];
    logic                    r_sat_p   [1:TREE_DEPTH];
    logic                    w_acc_step_sat;
    logic                    w_beat_sat;
    logic                    w_emit_sat;
    logic                    r_acc_sat;
`endif

    // Nothing moves unless the output register can take whatever arrives at the tree output.
    assign w_adv    = rst_n & ce & (~out_valid | out_ready);
    assign in_ready = w_adv;

    for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
        assign w_node[0][g] = y_ins[g*WIDTH +: WIDTH];
    end

    // ---- tree levels 1..TREE_DEPTH: registered saturating pairwise adds ----
    for (genvar k = 1; k <= TREE_DEPTH; k++) begin : g_lvl
        for (genvar i = 0; i < LANE_COUNT; i++) begin : g_node
            if (i < tree_nodes(LANE_COUNT, k)) begin : g_add
                logic signed [WIDTH-1:0] w_b;
                if (2*i + 1 < tree_nodes(LANE_COUNT, k - 1)) begin : g_pair
                    assign w_b = w_node[k-1][2*i+1];
                end else begin : g_odd
                    assign w_b = '0;
                end
                stacked_reducer_sat_add #(.WIDTH(WIDTH)) u_add (
                    .clk   (clk),
                    .i_en  (w_adv),
                    .i_a   (w_node[k-1][2*i]),
                    .i_b   (w_b),
                    .o_sum (w_node[k][i])
`ifdef STACKED_REDUCER_SAT_FLAG_EN
                    ,
                    .o_sat (w_nsat[k][i])
`endif
                );
            end else begin : g_unused
                assign w_node[k][i] = '0;
`ifdef STACKED_REDUCER_SAT_FLAG_EN
                assign w_nsat[k][i] = 1'b0;
`endif
            end
        end
`ifdef STACKED_REDUCER_SAT_FLAG_EN
        assign w_lvl_sat[k] = r_sat_p[k] | (|w_nsat[k]);
`endif
    end

    // Mode tags, PASS lanes and upstream saturation travel alongside the adder levels.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_mode_p[1] <= mode_e'(mode);
            r_pass_p[1] <= y_ins;
            for (int k = 2; k <= TREE_DEPTH; k++) begin
                r_mode_p[k] <= r_mode_p[k-1];
                r_pass_p[k] <= r_pass_p[k-1];
            end
`ifdef STACKED_REDUCER_SAT_FLAG_EN
            r_sat_p[1] <= 1'b0;
            for (int k = 2; k <= TREE_DEPTH; k++) begin
                r_sat_p[k] <= w_lvl_sat[k-1];
            end
`endif
        end
    end

    // ---- tree output: mode resolution and accumulation ----
    assign w_tvld  = r_vld_p[TREE_DEPTH];
    assign w_tmode = r_mode_p[TREE_DEPTH];
    assign w_sum   = w_node[TREE_DEPTH][0];

`ifdef STACKED_REDUCER_SAT_FLAG_EN
    assign w_acc_step_sat = (sat_add(wide_t'(r_acc), wide_t'(w_sum), WIDTH)
                             != (wide_t'(r_acc) + wide_t'(w_sum)));
    assign w_beat_sat     = r_acc_sat | w_lvl_sat[TREE_DEPTH] | w_acc_step_sat;
`endif

    always_comb begin
        w_emit     = 1'b0;
        w_acc_keep = 1'b0;
        w_data     = '0;
        w_acc_next = WIDTH'(sat_add(wide_t'(r_acc), wide_t'(w_sum), WIDTH));
        w_last     = (r_acc_cnt == CNT_W'(ACC_LEN - 1));
`ifdef STACKED_REDUCER_SAT_FLAG_EN
        w_emit_sat = 1'b0;
`endif
        if (w_tvld) begin
            case (w_tmode)
                MODE_ACCUM: begin
                    if (w_last) begin
                        w_emit              = 1'b1;
                        w_data[WIDTH-1:0]   = w_acc_next;
`ifdef STACKED_REDUCER_SAT_FLAG_EN
                        w_emit_sat          = w_beat_sat;
`endif
                    end else begin
                        w_acc_keep = 1'b1;
                    end
                end
                MODE_SUM: begin
                    w_emit            = 1'b1;
                    w_data[WIDTH-1:0] = w_sum;
`ifdef STACKED_REDUCER_SAT_FLAG_EN
                    w_emit_sat        = w_lvl_sat[TREE_DEPTH];
`endif
                end
                default: begin
                    w_emit = 1'b1;
                    w_data = r_pass_p[TREE_DEPTH];
                end
            endcase
        end
    end

    // ---- output register and control state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p   <= '0;
            r_acc     <= '0;
            r_acc_cnt <= '0;
            out_valid <= 1'b0;
            y_out     <= '0;
`ifdef STACKED_REDUCER_SAT_FLAG_EN
            r_acc_sat <= 1'b0;
            sat_flag  <= 1'b0;
`endif
        end else if (w_adv) begin
            r_vld_p[1] <= in_valid;
            for (int k = 2; k <= TREE_DEPTH; k++) begin
                r_vld_p[k] <= r_vld_p[k-1];
            end
            // Any non-continuing beat (final ACCUM or non-ACCUM) leaves the accumulator empty.
            if (w_tvld) begin
                if (w_acc_keep) begin
                    r_acc     <= w_acc_next;
                    r_acc_cnt <= r_acc_cnt + CNT_W'(1);
`ifdef STACKED_REDUCER_SAT_FLAG_EN
                    r_acc_sat <= w_beat_sat;
`endif
                end else begin
                    r_acc     <= '0;
                    r_acc_cnt <= '0;
`ifdef STACKED_REDUCER_SAT_FLAG_EN
                    r_acc_sat <= 1'b0;
`endif
                end
            end
            out_valid <= w_emit;
            if (w_emit) begin
                y_out <= w_data;
`ifdef STACKED_REDUCER_SAT_FLAG_EN
                sat_flag <= w_emit_sat;
`endif
            end
        end
    end

endmodule
